// File: rtl/uart_word_loader_pkg.sv
// Shared types and helpers for the UART word loader: FSM state encoding,
// default handshake bytes and the timeout counter width.
package uart_word_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    ACK   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'h4B;
  localparam logic [7:0] NAK_BYTE_DEFAULT = 8'h45;

  // Wide enough to hold any value 0..timeout.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/uart_word_loader_if.sv
// Receiver, memory-write and transmitter signals of the word loader.
// The master side is the loader; the slave side is its environment.
interface uart_word_loader_if #(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 8
);

  logic                    rx_valid;
  logic [7:0]              rx_data;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [8*WORD_BYTES-1:0] mem_wdata;
  logic                    tx_start;
  logic [7:0]              tx_data;
  logic                    tx_busy;

  modport master (
    input  rx_valid, rx_data, tx_busy,
    output mem_we, mem_addr, mem_wdata, tx_start, tx_data
  );

  modport slave (
    output rx_valid, rx_data, tx_busy,
    input  mem_we, mem_addr, mem_wdata, tx_start, tx_data
  );

endinterface

// File: rtl/uart_byte_event.sv
// Turns the receiver's byte-ready level into a single-cycle byte event.
// The history register resets high so a level already high at reset is ignored.
module uart_byte_event (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_valid,
  output logic byte_ev
);

  logic rx_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_valid_q <= 1'b1;
    else        rx_valid_q <= rx_valid;
  end

  assign byte_ev = rx_valid & ~rx_valid_q;

endmodule

// File: rtl/uart_word_loader.sv
// Assembles little-endian UART bytes into memory words, writes NUM_WORDS
// words at consecutive addresses, then sends an ACK or NAK byte.
module uart_word_loader
  import uart_word_loader_pkg::*;
#(
  parameter int         WORD_BYTES = 2,
  parameter int         ADDR_W     = 8,
  parameter int         NUM_WORDS  = 256,
  parameter int         TIMEOUT    = 100000,
  parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEFAULT,
  parameter logic [7:0] NAK_BYTE   = NAK_BYTE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  uart_word_loader_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int DATA_W  = 8 * WORD_BYTES;
  localparam int TIMER_W = timer_width(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [1:0]         CNT_LAST   = 2'(WORD_BYTES - 1);

  state_t             state, state_next;
  logic               byte_ev;
  logic [1:0]         byte_cnt;
  logic [ADDR_W-1:0]  addr;
  logic [TIMER_W-1:0] timer;
  logic [DATA_W-1:0]  word_buf, word_next;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_wdata_r;
  logic               ok;
  logic               error_r;
  logic               last_byte, timeout_hit;
  logic               mem_we_c, tx_start_c;
  logic [7:0]         tx_data_c;

  uart_byte_event u_byte_event (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (bus.rx_valid),
    .byte_ev  (byte_ev)
  );

  assign last_byte   = (byte_cnt == CNT_LAST);
  assign timeout_hit = (state == RECV) && !byte_ev && (byte_cnt != 2'd0) &&
                       (timer == TIMER_LAST);

  always_comb begin
    word_next = word_buf;
    word_next[{byte_cnt, 3'b000} +: 8] = bus.rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_we_c   = 1'b0;
    tx_start_c = 1'b0;
    tx_data_c  = 8'h00;
    case (state)
      IDLE:  if (start) state_next = RECV;
      RECV: begin
        if (byte_ev && last_byte) state_next = WRITE;
        else if (timeout_hit)     state_next = ACK;
      end
      WRITE: begin
        mem_we_c   = 1'b1;
        state_next = (addr == ADDR_LAST) ? ACK : RECV;
      end
      ACK: begin
        if (!bus.tx_busy) begin
          tx_start_c = 1'b1;
          tx_data_c  = ok ? ACK_BYTE : NAK_BYTE;
          state_next = DONE;
        end
      end
      DONE:    if (start) state_next = RECV;
      default: state_next = IDLE;
    endcase
  end

  // The write address and data are latched with the last byte so they stay
  // put after the write while the next word is being collected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt    <= 2'd0;
      addr        <= '0;
      timer       <= '0;
      word_buf    <= '0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      ok          <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            byte_cnt <= 2'd0;
            addr     <= '0;
            timer    <= '0;
            ok       <= 1'b0;
            error_r  <= 1'b0;
          end
        end
        RECV: begin
          if (byte_ev) begin
            word_buf <= word_next;
            timer    <= '0;
            if (last_byte) begin
              mem_addr_r  <= addr;
              mem_wdata_r <= word_next;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end else if (byte_cnt != 2'd0) begin
            if (timeout_hit) begin
              byte_cnt <= 2'd0;
              timer    <= '0;
              ok       <= 1'b0;
              error_r  <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        WRITE: begin
          byte_cnt <= 2'd0;
          if (addr == ADDR_LAST) ok <= 1'b1;
          else                   addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.tx_start  = tx_start_c;
  assign bus.tx_data   = tx_data_c;

  assign busy  = (state != IDLE) && (state != DONE);
  assign done  = (state == DONE);
  assign error = error_r;

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader; expected writes and transmit bytes are
// queued as stimulus is driven and popped by monitors when the DUT produces them.
module tb_uart_word_loader;

  localparam int WORD_BYTES = 2;
  localparam int ADDR_W     = 8;
  localparam int NUM_WORDS  = 3;
  localparam int TIMEOUT    = 20;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic error;

  int unsigned tests_run = 0;
  int unsigned failures  = 0;
  int unsigned tx_count  = 0;
  int unsigned tx_before;

  wr_t         wq[$];
  logic [7:0]  txq[$];

  uart_word_loader_if #(.WORD_BYTES(WORD_BYTES), .ADDR_W(ADDR_W)) bus ();

  uart_word_loader #(
    .WORD_BYTES (WORD_BYTES),
    .ADDR_W     (ADDR_W),
    .NUM_WORDS  (NUM_WORDS),
    .TIMEOUT    (TIMEOUT),
    .ACK_BYTE   (8'h4B),
    .NAK_BYTE   (8'h45)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input int high_cycles);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    repeat (high_cycles) @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check_output(tag, {31'd0, done}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (bus.mem_we) begin
      check_output("write_expected", {31'd0, wq.size() != 0}, 32'd1);
      if (wq.size() != 0) begin
        wr_t w;
        w = wq.pop_front();
        check_output("write_addr", {24'd0, bus.mem_addr}, {24'd0, w.addr});
        check_output("write_data", {16'd0, bus.mem_wdata}, {16'd0, w.data});
      end
    end
    if (bus.tx_start) begin
      tx_count++;
      check_output("tx_expected", {31'd0, txq.size() != 0}, 32'd1);
      if (txq.size() != 0) begin
        logic [7:0] t;
        t = txq.pop_front();
        check_output("tx_data", {24'd0, bus.tx_data}, {24'd0, t});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    bus.tx_busy  = 1'b0;
    #12;
    check_output("reset_flags", {27'd0, bus.mem_we, bus.tx_start, busy, done, error}, 32'd0);
    check_output("reset_addr", {24'd0, bus.mem_addr}, 32'd0);
    check_output("reset_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    check_output("reset_tx_data", {24'd0, bus.tx_data}, 32'd0);

    // Level held high across reset release must not count as a byte.
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulse_start();
    repeat (3) @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    @(negedge clk);
    check_output("busy_after_start", {31'd0, busy}, 32'd1);
    push_write(8'd0, 16'h2211);
    push_write(8'd1, 16'h4433);
    push_write(8'd2, 16'h6655);
    txq.push_back(8'h4B);
    apply_stimulus(8'h11, 6);
    apply_stimulus(8'h22, 6);
    apply_stimulus(8'h33, 6);
    apply_stimulus(8'h44, 6);
    apply_stimulus(8'h55, 6);
    apply_stimulus(8'h66, 6);
    wait_done("load1_done", 50);
    check_output("load1_error", {31'd0, error}, 32'd0);
    check_output("load1_busy", {31'd0, busy}, 32'd0);
    check_output("load1_tx_count", tx_count, 32'd1);

    // Bytes in DONE are ignored; start mid-word must not disturb the load.
    apply_stimulus(8'h77, 2);
    apply_stimulus(8'h78, 2);
    @(negedge clk);
    check_output("done_hold", {30'd0, done, busy}, 32'd2);
    pulse_start();
    push_write(8'd0, 16'h0201);
    push_write(8'd1, 16'h0403);
    push_write(8'd2, 16'h0605);
    txq.push_back(8'h4B);
    apply_stimulus(8'h01, 1);
    pulse_start();
    @(negedge clk);
    check_output("start_in_recv_busy", {30'd0, busy, done}, 32'd2);
    apply_stimulus(8'h02, 1);
    apply_stimulus(8'h03, 1);
    apply_stimulus(8'h04, 1);
    apply_stimulus(8'h05, 1);
    apply_stimulus(8'h06, 1);
    wait_done("load2_done", 50);
    check_output("load2_tx_count", tx_count, 32'd2);

    // Partial word followed by silence aborts with NAK.
    pulse_start();
    txq.push_back(8'h45);
    apply_stimulus(8'h11, 6);
    repeat (8) @(negedge clk);
    check_output("timeout_not_early", {30'd0, busy, error}, 32'd2);
    wait_done("timeout_done", TIMEOUT + 20);
    check_output("timeout_error", {31'd0, error}, 32'd1);
    check_output("timeout_tx_count", tx_count, 32'd3);
    check_output("timeout_no_write", wq.size(), 32'd0);

    // Long gap between whole words, then transmitter busy at load end.
    pulse_start();
    @(negedge clk);
    check_output("error_cleared", {31'd0, error}, 32'd0);
    push_write(8'd0, 16'hBBAA);
    push_write(8'd1, 16'hDDCC);
    push_write(8'd2, 16'hFFEE);
    txq.push_back(8'h4B);
    apply_stimulus(8'hAA, 3);
    apply_stimulus(8'hBB, 3);
    repeat (3 * TIMEOUT) @(negedge clk);
    check_output("gap_no_timeout", {30'd0, busy, error}, 32'd2);
    bus.tx_busy = 1'b1;
    apply_stimulus(8'hCC, 3);
    apply_stimulus(8'hDD, 3);
    apply_stimulus(8'hEE, 3);
    apply_stimulus(8'hFF, 3);
    tx_before = tx_count;
    repeat (50) @(negedge clk);
    check_output("tx_held_off", tx_count, tx_before);
    check_output("ack_wait_busy", {30'd0, busy, done}, 32'd2);
    @(posedge clk);
    #1 bus.tx_busy = 1'b0;
    @(negedge clk);
    check_output("tx_fires", {31'd0, bus.tx_start}, 32'd1);
    @(negedge clk);
    check_output("tx_once", {30'd0, bus.tx_start, done}, 32'd1);
    check_output("tx_busy_count", tx_count, tx_before + 1);

    // Reset mid-load, then a fresh load from address 0.
    pulse_start();
    push_write(8'd0, 16'h2211);
    apply_stimulus(8'h11, 3);
    apply_stimulus(8'h22, 3);
    apply_stimulus(8'h33, 3);
    #2 rst_n = 1'b0;
    #1;
    check_output("midreset_flags", {27'd0, bus.mem_we, bus.tx_start, busy, done, error}, 32'd0);
    check_output("midreset_addr", {24'd0, bus.mem_addr}, 32'd0);
    check_output("midreset_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    push_write(8'd0, 16'h8281);
    push_write(8'd1, 16'h8483);
    push_write(8'd2, 16'h8685);
    txq.push_back(8'h4B);
    pulse_start();
    apply_stimulus(8'h81, 3);
    apply_stimulus(8'h82, 3);
    apply_stimulus(8'h83, 3);
    apply_stimulus(8'h84, 3);
    apply_stimulus(8'h85, 3);
    apply_stimulus(8'h86, 3);
    wait_done("restart_done", 50);
    check_output("restart_error", {31'd0, error}, 32'd0);

    repeat (2) @(negedge clk);
    check_output("write_queue_drained", wq.size(), 32'd0);
    check_output("tx_queue_drained", txq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Receive-side consumer for the UART receiver. It edge-detects the receiver's byte-ready strobe and assembles little-endian bytes into memory words. It writes a fixed number of words into the processor's instruction/data RAM at consecutive addresses. When the load completes it hands one acknowledge byte to the UART transmitter.

## Interface
Parameters:
- WORD_BYTES, 2, bytes per memory word; legal values 1–4.
- ADDR_W, 8, memory address width.
- NUM_WORDS, 256, words per load; legal range 1..2^ADDR_W.
- TIMEOUT, 100000, idle clocks allowed mid-word before abort; must be ≥1.
- ACK_BYTE, 8'h4B, byte sent on successful completion.
- NAK_BYTE, 8'h45, byte sent on timeout abort.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; arms a new load.
- rx_valid  in  1  receiver byte-ready; level, may stay high for up to 8 cycles per byte.
- rx_data  in  8  received byte; stable while rx_valid is high.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8*WORD_BYTES  assembled word.
- tx_start  out  1  one-cycle request to the transmitter.
- tx_data  out  8  byte to transmit; valid while tx_start is high.
- tx_busy  in  1  transmitter busy.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE until the next start.
- error  out  1  sticky timeout flag; cleared by start.

## Operation
- Byte event: rx_valid==1 && rx_valid_q==0, where rx_valid_q is rx_valid registered. Each rx_valid high period yields exactly one byte.
- FSM states:
  - IDLE: start goes to RECV; clears addr, byte_cnt, timer and error.
  - RECV: on each byte event, place the byte into lane byte_cnt (first byte goes to bits [7:0]) and increment byte_cnt. On the event with byte_cnt==WORD_BYTES-1, go to WRITE.
  - WRITE: assert mem_we for one cycle. Clear byte_cnt. If addr==NUM_WORDS-1, go to ACK with ok=1. Otherwise increment addr and return to RECV.
  - ACK: wait for tx_busy==0, then pulse tx_start with tx_data = ok ? ACK_BYTE : NAK_BYTE and go to DONE.
  - DONE: hold done. start goes to RECV with the same clearing as IDLE.
- Byte events seen in IDLE, WRITE, ACK or DONE are ignored.
- Timeout:
  - The timer counts only in RECV when byte_cnt!=0. It resets on every byte event.
  - When it reaches TIMEOUT-1: discard the partial word, set error, and go to ACK with ok=0. No mem_we is issued.
  - An idle gap between whole words never times out.
- start while busy is ignored.
- Addresses wrap naturally only if NUM_WORDS==2^ADDR_W. In that case the final address is all-ones and no wrap write occurs.

## Timing
- Reset values:
  - All outputs 0; mem_wdata 0; tx_data 0.
  - rx_valid_q resets to 1, so a level already high at reset release is not counted.
- Latency:
  - A byte is captured on the clock edge where the event is detected.
  - mem_we is asserted the cycle after the last byte of a word is captured.
  - mem_addr and mem_wdata are stable during mem_we and hold until the next write.
- tx_start is asserted no earlier than the cycle after the final WRITE, or after the timeout. It is delayed while tx_busy=1.
- Reset mid-load: all state returns to IDLE immediately and no further mem_we is issued. Memory contents already written are not rolled back.
- Minimum throughput: one byte every 2 cycles; two back-to-back rx_valid pulses separated by one low cycle are both accepted.

## Structure
- A shared loader package holds:
  - the state enum (IDLE, RECV, WRITE, ACK, DONE);
  - defaults for ACK_BYTE and NAK_BYTE;
  - a function returning the timer width, ceil(log2(TIMEOUT+1)).
- One sub-module, uart_byte_event, holds the rx_valid_q register and the edge detect. The datapath and FSM stay in this module.

## Test plan
- WORD_BYTES=2, NUM_WORDS=3; bytes 11 22 33 44 55 66, each with rx_valid high 6 cycles -> writes (0,2211), (1,4433), (2,6655), then tx_data=4B, done=1, error=0.
- rx_valid already high at reset release, then the 6-byte sequence above -> the held-high level produces no byte and no extra write.
- One byte 11 then silence for TIMEOUT cycles -> no mem_we, error=1, tx_data=45 once, done=1.
- tx_busy held high for 50 cycles at load end -> tx_start waits and fires once on the first cycle after tx_busy falls.
- rst_n pulsed low after 3 of 6 bytes -> outputs 0 immediately; a restart with 6 fresh bytes writes from address 0.
- start pulsed during RECV, and bytes arriving in DONE -> no state change; no writes.
